// File: rtl/keyboard_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keyboard_pkg;

    typedef enum logic [1:0] {
        SCAN        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } kb_state_e;

    // One-cold row drive patterns, in scan order.
    localparam logic [3:0] ROW0   = 4'b1110;
    localparam logic [3:0] ROW1   = 4'b1101;
    localparam logic [3:0] ROW2   = 4'b1011;
    localparam logic [3:0] ROW3   = 4'b0111;
    localparam logic [3:0] LINES_IDLE = 4'b1111;

    // Index of the lowest low bit; the lowest index wins when several are low.
    function automatic logic [1:0] cold_idx(input logic [3:0] v);
        logic [1:0] idx;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    // Next row in the rotation; any illegal pattern recovers to ROW0.
    function automatic logic [3:0] row_next(input logic [3:0] r);
        logic [3:0] nxt;
        case (r)
            ROW0:    nxt = ROW1;
            ROW1:    nxt = ROW2;
            ROW2:    nxt = ROW3;
            default: nxt = ROW0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/keyboard_debounce.sv
// Stability counter: counts consecutive samples equal to a reference and
// flags the cycle on which the DEBOUNCE_CYCLES-th matching sample arrives.
module keyboard_debounce
    import keyboard_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [3:0] sample_i,
    input  logic [3:0] ref_i,
    output logic       match_o,
    output logic       done_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    assign match_o = (sample_i == ref_i);
    assign done_o  = en_i && match_o && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    // Counter is held clear whenever the FSM is not debouncing, so every
    // debounce window starts from zero.
    always_ff @(posedge clk) begin
        if (rst || !en_i)
            cnt_q <= '0;
        else if (match_o)
            cnt_q <= cnt_q + 1'b1;
        else
            cnt_q <= '0;
    end

endmodule

// File: rtl/keyboard.sv
// 4x4 active-low keypad scanner with press/release debounce.
module keyboard
    import keyboard_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int SCAN_DWELL      = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] num,
    output logic       pressed,
    output logic       toggle
);

    localparam int DW = $clog2(SCAN_DWELL + 1);

    logic [3:0]    col_meta_q, col_s_q;
    kb_state_e     state_q;
    logic [3:0]    row_q;
    logic [DW-1:0] dwell_q;
    logic [3:0]    cand_col_q;
    logic [3:0]    cand_code_q;
    logic [3:0]    num_q;
    logic          pressed_q, toggle_q;

    logic          deb_en, deb_match, deb_done;
    logic [3:0]    deb_ref;
    logic          dwell_last;

    assign row     = row_q;
    assign num     = num_q;
    assign pressed = pressed_q;
    assign toggle  = toggle_q;

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_q <= LINES_IDLE;
            col_s_q    <= LINES_IDLE;
        end else begin
            col_meta_q <= col;
            col_s_q    <= col_meta_q;
        end
    end

    // Press debounce compares against the captured column pattern, release
    // debounce against all-open.
    assign deb_en     = (state_q == DEB_PRESS) || (state_q == DEB_RELEASE);
    assign deb_ref    = (state_q == DEB_PRESS) ? cand_col_q : LINES_IDLE;
    assign dwell_last = (dwell_q == DW'(SCAN_DWELL - 1));

    keyboard_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk      (clk),
        .rst      (rst),
        .en_i     (deb_en),
        .sample_i (col_s_q),
        .ref_i    (deb_ref),
        .match_o  (deb_match),
        .done_o   (deb_done)
    );

    // Scan / debounce FSM with registered key outputs. Rows are only
    // evaluated on the last dwell cycle so the two-cycle synchronizer lag
    // never attributes a column hit to the wrong row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            row_q       <= ROW0;
            dwell_q     <= '0;
            cand_col_q  <= LINES_IDLE;
            cand_code_q <= '0;
            num_q       <= '0;
            pressed_q   <= 1'b0;
            toggle_q    <= 1'b0;
        end else begin
            unique case (state_q)
                SCAN: begin
                    if (dwell_last) begin
                        dwell_q <= '0;
                        if (col_s_q != LINES_IDLE) begin
                            cand_col_q  <= col_s_q;
                            cand_code_q <= {cold_idx(row_q), cold_idx(col_s_q)};
                            state_q     <= DEB_PRESS;
                        end else begin
                            row_q <= row_next(row_q);
                        end
                    end else begin
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (deb_done) begin
                        num_q     <= cand_code_q;
                        pressed_q <= 1'b1;
                        toggle_q  <= ~toggle_q;
                        state_q   <= HELD;
                    end else if (!deb_match) begin
                        // Bounce: rescan the same row from a fresh dwell.
                        dwell_q <= '0;
                        state_q <= SCAN;
                    end
                end
                HELD: begin
                    if (col_s_q == LINES_IDLE)
                        state_q <= DEB_RELEASE;
                end
                DEB_RELEASE: begin
                    if (deb_done) begin
                        pressed_q <= 1'b0;
                        dwell_q   <= '0;
                        state_q   <= SCAN;
                    end else if (!deb_match) begin
                        state_q <= HELD;
                    end
                end
                default: begin
                    state_q <= SCAN;
                    dwell_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keyboard.sv
// Self-checking bench for the keypad scanner: a keypad model closes the
// selected key's row/column contact, a scoreboard tracks accepted presses.
module tb_keyboard;

    localparam int PRESS_MAX   = 4 * 3 + 2 + 8;  // worst-case press latency
    localparam int RELEASE_MAX = 2 + 1 + 8;      // sync + detect + debounce

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row, col, num;
    logic       pressed, toggle;

    // keypad model
    logic       key_dn;
    int         key_k;

    // scoreboard
    int         errors = 0;
    int         checks = 0;
    int         tog_edges = 0;
    int         prs_edges = 0;
    int         exp_presses = 0;
    logic [3:0] exp_num = 4'd0;

    keyboard dut (
        .clk     (clk),
        .rst     (rst),
        .row     (row),
        .col     (col),
        .num     (num),
        .pressed (pressed),
        .toggle  (toggle)
    );

    always #5 clk = ~clk;

    // Closed contact pulls the key's column low only while its row is driven.
    always_comb begin
        logic [3:0] one;
        one = 4'b0001;
        col = 4'b1111;
        if (key_dn && row == ~(one << (key_k / 4)))
            col = ~(one << (key_k % 4));
    end

    always @(toggle)  tog_edges = tog_edges + 1;
    always @(pressed) prs_edges = prs_edges + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_press(input int k, output logic ok, output int used);
        ok = 1'b0;
        used = 0;
        while (!ok && used < PRESS_MAX) begin
            step(1);
            used++;
            if (pressed && num == 4'(k)) ok = 1'b1;
        end
    endtask

    task automatic wait_release(output logic ok, output int used);
        ok = 1'b0;
        used = 0;
        while (!ok && used < RELEASE_MAX) begin
            step(1);
            used++;
            if (!pressed) ok = 1'b1;
        end
    endtask

    initial begin
        logic [3:0] rows [4];
        int         order [16];
        int         used, t0, p0, bad, tmp, j, k, len;
        logic       ok;

        rows[0] = 4'b1110; rows[1] = 4'b1101; rows[2] = 4'b1011; rows[3] = 4'b0111;
        key_dn = 1'b0;
        key_k  = 0;

        // reset and idle scan
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        chk("rst_num", num, 0);
        chk("rst_pressed", pressed, 0);
        chk("rst_toggle", toggle, 0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("scan_row%0d", i), row, rows[(i / 3) % 4]);
            step(1);
        end

        // every key once, in random order
        for (int i = 0; i < 16; i++) order[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        t0 = tog_edges;
        for (int i = 0; i < 16; i++) begin
            k = order[i];
            p0 = tog_edges;
            key_k = k; key_dn = 1'b1;
            wait_press(k, ok, used);
            chk($sformatf("press_lat_k%0d", k), ok, 1);
            exp_presses++; exp_num = 4'(k);
            step(50 - used);
            chk($sformatf("held_k%0d", k), {pressed, num}, {1'b1, exp_num});
            key_dn = 1'b0;
            wait_release(ok, used);
            chk($sformatf("release_lat_k%0d", k), ok, 1);
            step(100 - used);
            chk($sformatf("num_hold_k%0d", k), num, exp_num);
            chk($sformatf("tog_once_k%0d", k), tog_edges - p0, 1);
        end
        chk("tog_total16", tog_edges - t0, 16);
        chk("tog_parity", toggle, exp_presses[0]);

        // long press of key 2: no auto-repeat, row frozen
        p0 = tog_edges;
        key_k = 2; key_dn = 1'b1;
        wait_press(2, ok, used);
        chk("long_press_lat", ok, 1);
        exp_presses++; exp_num = 4'd2;
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            step(1);
            if (!(pressed && num == 4'd2 && row == 4'b1110)) bad++;
        end
        chk("long_press_stable", bad, 0);
        chk("long_press_tog", tog_edges - p0, 1);
        key_dn = 1'b0;
        wait_release(ok, used);
        chk("long_release", ok, 1);
        step(60);

        // press chatter on key 5
        p0 = tog_edges; t0 = prs_edges;
        key_k = 5;
        for (int i = 0; i < 20; i++) begin
            key_dn = (i % 2 == 0);
            step(1);
        end
        chk("pchat_no_tog", tog_edges - p0, 0);
        chk("pchat_no_press", prs_edges - t0, 0);
        key_dn = 1'b1;
        wait_press(5, ok, used);
        chk("pchat_accept", ok, 1);
        exp_presses++; exp_num = 4'd5;
        step(20);
        chk("pchat_one_tog", tog_edges - p0, 1);
        chk("pchat_num", num, exp_num);

        // release chatter on key 5
        p0 = tog_edges; t0 = prs_edges; bad = 0;
        for (int i = 0; i < 20; i++) begin
            key_dn = (i % 2 == 1);
            step(1);
            if (!pressed) bad++;
        end
        chk("rchat_pressed_held", bad, 0);
        key_dn = 1'b0;
        wait_release(ok, used);
        chk("rchat_release", ok, 1);
        step(30);
        chk("rchat_one_fall", prs_edges - t0, 1);
        chk("rchat_no_tog", tog_edges - p0, 0);

        // short random glitches (< DEBOUNCE_CYCLES closed samples) never accept
        for (int i = 0; i < 6; i++) begin
            p0 = tog_edges; t0 = prs_edges;
            key_k = $urandom_range(0, 15);
            len = $urandom_range(1, 7);
            key_dn = 1'b1;
            step(len);
            key_dn = 1'b0;
            step(40);
            chk($sformatf("glitch%0d_k%0d_l%0d", i, key_k, len),
                {tog_edges - p0, prs_edges - t0, num}, {32'd0, 32'd0, exp_num});
        end
        chk("glitch_tog_parity", toggle, exp_presses[0]);

        // reset while held
        key_k = $urandom_range(1, 15);
        key_dn = 1'b1;
        wait_press(key_k, ok, used);
        chk("pre_reset_press", ok, 1);
        step(5);
        rst = 1'b1;
        step(1);
        exp_presses = 0; exp_num = 4'd0;
        chk("mid_rst_pressed", pressed, 0);
        chk("mid_rst_num", num, exp_num);
        chk("mid_rst_toggle", toggle, exp_presses[0]);
        chk("mid_rst_row", row, 4'b1110);
        key_dn = 1'b0;
        rst = 1'b0;
        step(30);
        chk("post_rst_idle", {pressed, num}, {1'b0, 4'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
